// File: rtl/bsg_print_stat_snoop_multi.sv
// ============================================================================
//  Module   : bsg_print_stat_snoop_multi
//  Purpose  : Passive multi-channel snoop of print-stat stores; timestamped hits
//             are merged round-robin into one shared FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_print_stat_snoop_multi #(
    parameter int                    NUM_CH_P     = 4,
    parameter int                    ADDR_WIDTH_P = 28,
    parameter int                    DATA_WIDTH_P = 32,
    parameter logic [ADDR_WIDTH_P-1:0] STAT_EPA_P = 'h1D0C,
    parameter int                    ELS_P        = 8,
    parameter int                    CTR_WIDTH_P  = 64,
    parameter int                    DROP_WIDTH_P = 16,
    localparam int                   c_CH_W       = (NUM_CH_P > 1) ? $clog2(NUM_CH_P) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [NUM_CH_P-1:0]              v_i,
    input  logic [NUM_CH_P-1:0]              ready_i,
    input  logic [NUM_CH_P-1:0]              store_i,
    input  logic [NUM_CH_P*ADDR_WIDTH_P-1:0] addr_i,
    input  logic [NUM_CH_P*DATA_WIDTH_P-1:0] data_i,
    output logic                             stat_v_o,
    output logic [c_CH_W-1:0]                stat_ch_o,
    output logic [DATA_WIDTH_P-1:0]          stat_tag_o,
    output logic [CTR_WIDTH_P-1:0]           stat_time_o,
    input  logic                             stat_yumi_i,
    output logic [CTR_WIDTH_P-1:0]           ctr_o,
    output logic [DROP_WIDTH_P-1:0]          drop_o
);

    localparam int c_PTR_W  = (ELS_P > 1) ? $clog2(ELS_P) : 1;
    localparam int c_CNT_W  = $clog2(ELS_P + 1);
    localparam int c_DCNT_W = $clog2(NUM_CH_P + 1);
    localparam int c_SUM_W  = DROP_WIDTH_P + c_DCNT_W;
    localparam int c_ENT_W  = c_CH_W + DATA_WIDTH_P + CTR_WIDTH_P;

    logic [CTR_WIDTH_P-1:0]  r_ctr;
    logic [DROP_WIDTH_P-1:0] r_drop;
    logic [NUM_CH_P-1:0]     w_hit;
    logic [NUM_CH_P-1:0]     w_gnt_clr;
    logic [NUM_CH_P-1:0]     w_drop;
    logic [NUM_CH_P-1:0]     r_pend_v;
    logic [DATA_WIDTH_P-1:0] r_pend_tag  [NUM_CH_P];
    logic [CTR_WIDTH_P-1:0]  r_pend_time [NUM_CH_P];
    logic [c_CH_W-1:0]       r_start;
    logic [c_CH_W:0]         w_rr_sum;
    logic [c_CH_W-1:0]       w_gnt_ch;
    logic                    w_gnt_v;
    logic [c_DCNT_W-1:0]     w_dcnt;
    logic [c_SUM_W-1:0]      w_dsum;
    logic [c_ENT_W-1:0]      r_mem [ELS_P];
    logic [c_PTR_W-1:0]      r_wr;
    logic [c_PTR_W-1:0]      r_rd;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    w_full;
    logic                    w_deq;

    genvar g;
    generate
        for (g = 0; g < NUM_CH_P; g++) begin : g_ch
            assign w_hit[g] = v_i[g] & ready_i[g] & store_i[g]
                            & (addr_i[g*ADDR_WIDTH_P +: ADDR_WIDTH_P] == STAT_EPA_P);
            assign w_gnt_clr[g] = w_gnt_v & (w_gnt_ch == c_CH_W'(g));
            assign w_drop[g]    = w_hit[g] & r_pend_v[g] & ~w_gnt_clr[g];
        end
    endgenerate

    assign w_full = (r_cnt == c_CNT_W'(ELS_P));
    assign w_deq  = stat_yumi_i & (r_cnt != '0);

    // r_start is the first channel searched; it sits one past the last grant
    always_comb begin
        w_gnt_v  = 1'b0;
        w_gnt_ch = '0;
        w_rr_sum = '0;
        if (!w_full) begin
            for (int k = 0; k < NUM_CH_P; k++) begin
                w_rr_sum = {1'b0, r_start} + (c_CH_W+1)'(k);
                if (w_rr_sum >= (c_CH_W+1)'(NUM_CH_P))
                    w_rr_sum = w_rr_sum - (c_CH_W+1)'(NUM_CH_P);
                if (!w_gnt_v && r_pend_v[w_rr_sum[c_CH_W-1:0]]) begin
                    w_gnt_v  = 1'b1;
                    w_gnt_ch = w_rr_sum[c_CH_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_dcnt = '0;
        for (int k = 0; k < NUM_CH_P; k++)
            w_dcnt = w_dcnt + c_DCNT_W'(w_drop[k]);
        w_dsum = c_SUM_W'(r_drop) + c_SUM_W'(w_dcnt);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ctr   <= '0;
            r_drop  <= '0;
            r_start <= '0;
        end else begin
            r_ctr <= r_ctr + 1'b1;
            if (w_dsum > c_SUM_W'({DROP_WIDTH_P{1'b1}}))
                r_drop <= {DROP_WIDTH_P{1'b1}};
            else
                r_drop <= w_dsum[DROP_WIDTH_P-1:0];
            if (w_gnt_v)
                r_start <= (w_gnt_ch == c_CH_W'(NUM_CH_P-1)) ? '0 : w_gnt_ch + 1'b1;
        end
    end

    // A granted slot is freed and may be reloaded by a hit in the same cycle
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_CH_P; k++) begin
            if (reset_i) begin
                r_pend_v[k] <= 1'b0;
            end else if (w_hit[k] && (!r_pend_v[k] || w_gnt_clr[k])) begin
                r_pend_v[k]    <= 1'b1;
                r_pend_tag[k]  <= data_i[k*DATA_WIDTH_P +: DATA_WIDTH_P];
                r_pend_time[k] <= r_ctr;
            end else if (w_gnt_clr[k]) begin
                r_pend_v[k] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_gnt_v)
            r_mem[r_wr] <= {w_gnt_ch, r_pend_tag[w_gnt_ch], r_pend_time[w_gnt_ch]};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_gnt_v)
                r_wr <= (r_wr == c_PTR_W'(ELS_P-1)) ? '0 : r_wr + 1'b1;
            if (w_deq)
                r_rd <= (r_rd == c_PTR_W'(ELS_P-1)) ? '0 : r_rd + 1'b1;
            if (w_gnt_v && !w_deq)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_gnt_v && w_deq)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign stat_v_o = (r_cnt != '0);
    assign {stat_ch_o, stat_tag_o, stat_time_o} = r_mem[r_rd];
    assign ctr_o  = r_ctr;
    assign drop_o = r_drop;

`ifndef SYNTHESIS
    a_yumi_valid : assert property (@(posedge clk_i) disable iff (reset_i) stat_yumi_i |-> stat_v_o);
    a_num_ch     : assert property (@(posedge clk_i) NUM_CH_P >= 1);
    a_els        : assert property (@(posedge clk_i) ELS_P >= 2);
`endif

endmodule

`default_nettype wire
